// File: rtl/commit_serializer_if.sv
// Write-port and word-stream bundle for commit_serializer.
// The slave side is the serializer; the master side drives writes and consumes words.
interface commit_serializer_if #(
  parameter int DPI_WIDTH   = 32,
  parameter int KEY_WIDTH   = 64,
  parameter int VALUE_WIDTH = 128,
  parameter int DEPTH       = 8
);
  logic                     we1_i;
  logic [KEY_WIDTH-1:0]     wa1_i;
  logic [VALUE_WIDTH-1:0]   wd1_i;
  logic                     we2_i;
  logic [KEY_WIDTH-1:0]     wa2_i;
  logic [VALUE_WIDTH-1:0]   wd2_i;
  logic                     in_ready_o;
  logic [DPI_WIDTH-1:0]     word_o;
  logic                     word_valid_o;
  logic                     word_ready_i;
  logic                     last_o;
  logic [$clog2(DEPTH):0]   fifo_count_o;
  logic                     overflow_o;

  modport master (
    output we1_i, wa1_i, wd1_i, we2_i, wa2_i, wd2_i, word_ready_i,
    input  in_ready_o, word_o, word_valid_o, last_o, fifo_count_o, overflow_o
  );

  modport slave (
    input  we1_i, wa1_i, wd1_i, we2_i, wa2_i, wd2_i, word_ready_i,
    output in_ready_o, word_o, word_valid_o, last_o, fifo_count_o, overflow_o
  );
endinterface

// File: rtl/commit_serializer.sv
// Dual-port {key,value} commit FIFO serialized into DPI_WIDTH words, key then value, LSW first.
// Define COMMIT_SERIALIZER_HEADER_EN to prefix each entry with a {A5,00,seq} header word.
module commit_serializer #(
  parameter int DPI_WIDTH   = 32,
  parameter int KEY_WIDTH   = 64,
  parameter int VALUE_WIDTH = 128,
  parameter int DEPTH       = 8
) (
  input logic               clk_i,
  input logic               rst_i,
  commit_serializer_if.slave bus
);
  localparam int KW = KEY_WIDTH / DPI_WIDTH;
  localparam int VW = VALUE_WIDTH / DPI_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int MW = (KW > VW) ? KW : VW;
  localparam int IW = $clog2(MW + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] KEY   = 2'd1;
  localparam logic [1:0] VALUE = 2'd2;
`ifdef COMMIT_SERIALIZER_HEADER_EN
  localparam logic [1:0] HDR   = 2'd3;
  localparam logic [1:0] FIRST = HDR;
`else
  localparam logic [1:0] FIRST = KEY;
`endif

  logic [KEY_WIDTH-1:0]   key_mem [DEPTH];
  logic [VALUE_WIDTH-1:0] val_mem [DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count, count_next, free;
  logic [1:0]             state, state_next;
  logic [IW-1:0]          idx, idx_next;
  logic                   overflow;
  logic                   req1, req2, acc1, acc2, drop;
  logic                   valid, xfer, pop, key_last, val_last;
  logic [KEY_WIDTH-1:0]   key_cur;
  logic [VALUE_WIDTH-1:0] val_cur;
  logic [DPI_WIDTH-1:0]   word;
`ifdef COMMIT_SERIALIZER_HEADER_EN
  logic [15:0]            seq;
`endif

  assign valid    = (state != IDLE);
  assign xfer     = valid && bus.word_ready_i;
  assign key_last = (idx == IW'(KW - 1));
  assign val_last = (idx == IW'(VW - 1));
  assign pop      = xfer && (state == VALUE) && val_last;

  // Same-key double write collapses to port 2; on shortage port 2 is dropped first.
  assign req1 = bus.we1_i && !(bus.we2_i && (bus.wa1_i == bus.wa2_i)) && !rst_i;
  assign req2 = bus.we2_i && !rst_i;
  assign free = CW'(DEPTH) - count + CW'(pop);
  assign acc1 = req1 && (free != '0);
  assign acc2 = req2 && (free >= (acc1 ? CW'(2) : CW'(1)));
  assign drop = (req1 && !acc1) || (req2 && !acc2);
  assign count_next = count + CW'(acc1) + CW'(acc2) - CW'(pop);

  assign key_cur = key_mem[rd_ptr];
  assign val_cur = val_mem[rd_ptr];

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: if (count_next != '0) begin
        state_next = FIRST;
        idx_next   = '0;
      end
`ifdef COMMIT_SERIALIZER_HEADER_EN
      HDR: if (xfer) state_next = KEY;
`endif
      KEY: if (xfer) begin
        if (key_last) begin
          state_next = VALUE;
          idx_next   = '0;
        end else begin
          idx_next = idx + IW'(1);
        end
      end
      VALUE: if (xfer) begin
        if (val_last) begin
          state_next = (count_next != '0) ? FIRST : IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx + IW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    word = '0;
    case (state)
`ifdef COMMIT_SERIALIZER_HEADER_EN
      HDR:   word = DPI_WIDTH'({8'hA5, 8'h00, seq});
`endif
      KEY:   word = key_cur[int'(idx)*DPI_WIDTH +: DPI_WIDTH];
      VALUE: word = val_cur[int'(idx)*DPI_WIDTH +: DPI_WIDTH];
      default: word = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      idx      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      wr_ptr <= wr_ptr + PW'(acc1) + PW'(acc2);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count_next;
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef COMMIT_SERIALIZER_HEADER_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)    seq <= '0;
    else if (pop) seq <= seq + 16'd1;
  end
`endif

  // Entry storage carries no reset; pointers and count define what is live.
  always_ff @(posedge clk_i) begin
    if (acc1) begin
      key_mem[wr_ptr] <= bus.wa1_i;
      val_mem[wr_ptr] <= bus.wd1_i;
    end
    if (acc2) begin
      key_mem[wr_ptr + PW'(acc1)] <= bus.wa2_i;
      val_mem[wr_ptr + PW'(acc1)] <= bus.wd2_i;
    end
  end

  assign bus.word_o       = word;
  assign bus.word_valid_o = valid;
  assign bus.last_o       = (state == VALUE) && val_last;
  assign bus.fifo_count_o = count;
  assign bus.overflow_o   = overflow;
  assign bus.in_ready_o   = (count <= CW'(DEPTH - 2));
endmodule

// File: tb/tb_commit_serializer.sv
// Directed bench for commit_serializer (DEPTH=8, 32-bit words, 64-bit key, 128-bit value).
// Follows COMMIT_SERIALIZER_HEADER_EN so header words are expected when the feature is built in.
module tb_commit_serializer;
  localparam int DPI_WIDTH   = 32;
  localparam int KEY_WIDTH   = 64;
  localparam int VALUE_WIDTH = 128;
  localparam int DEPTH       = 8;

  logic        clk = 1'b0;
  logic        rst;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] hdr_seq = 16'd0;
  logic [31:0] ew [0:6];
  int          en;

  commit_serializer_if #(.DPI_WIDTH(DPI_WIDTH), .KEY_WIDTH(KEY_WIDTH),
                         .VALUE_WIDTH(VALUE_WIDTH), .DEPTH(DEPTH)) bus ();

  commit_serializer #(.DPI_WIDTH(DPI_WIDTH), .KEY_WIDTH(KEY_WIDTH),
                      .VALUE_WIDTH(VALUE_WIDTH), .DEPTH(DEPTH))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we1, input logic [63:0] wa1, input logic [127:0] wd1,
                       input logic we2, input logic [63:0] wa2, input logic [127:0] wd2);
    bus.we1_i = we1; bus.wa1_i = wa1; bus.wd1_i = wd1;
    bus.we2_i = we2; bus.wa2_i = wa2; bus.wd2_i = wd2;
  endtask

  task automatic idle_ports;
    drive(1'b0, 64'd0, 128'd0, 1'b0, 64'd0, 128'd0);
  endtask

  task automatic load_entry(input logic [63:0] key, input logic [127:0] val);
    en = 0;
`ifdef COMMIT_SERIALIZER_HEADER_EN
    ew[en] = {8'hA5, 8'h00, hdr_seq};
    en++;
`endif
    for (int i = 0; i < 2; i++) begin ew[en] = key[i*32 +: 32]; en++; end
    for (int i = 0; i < 4; i++) begin ew[en] = val[i*32 +: 32]; en++; end
  endtask

  task automatic expect_word(input string tag, input logic [31:0] exp, input logic exp_last);
    chk({tag, "_valid"}, 128'(bus.word_valid_o), 128'(1'b1));
    chk({tag, "_word"},  128'(bus.word_o),       128'(exp));
    chk({tag, "_last"},  128'(bus.last_o),       128'(exp_last));
    tick;
  endtask

  task automatic expect_entry(input string tag, input logic [63:0] key, input logic [127:0] val);
    load_entry(key, val);
    for (int k = 0; k < en; k++) expect_word(tag, ew[k], k == en - 1);
    hdr_seq++;
  endtask

  initial begin
    rst = 1'b1;
    idle_ports;
    bus.word_ready_i = 1'b0;
    tick; tick;
    rst = 1'b0;

    chk("rst_valid",    128'(bus.word_valid_o), 128'(1'b0));
    chk("rst_last",     128'(bus.last_o),       128'(1'b0));
    chk("rst_word",     128'(bus.word_o),       128'(32'h0));
    chk("rst_count",    128'(bus.fifo_count_o), 128'(4'd0));
    chk("rst_overflow", 128'(bus.overflow_o),   128'(1'b0));
    chk("rst_in_ready", 128'(bus.in_ready_o),   128'(1'b1));

    // Single write streamed with the consumer always ready
    bus.word_ready_i = 1'b1;
    drive(1'b1, 64'h0000_0002_0000_0001, 128'h00000004_00000003_00000002_00000001,
          1'b0, 64'd0, 128'd0);
    tick;
    idle_ports;
    expect_entry("single", 64'h0000_0002_0000_0001, 128'h00000004_00000003_00000002_00000001);
    chk("single_count_end", 128'(bus.fifo_count_o), 128'(4'd0));
    chk("single_valid_end", 128'(bus.word_valid_o), 128'(1'b0));

    // Both ports on the same key: only port 2 survives
    drive(1'b1, 64'd5, 128'd7, 1'b1, 64'd5, 128'd9);
    tick;
    idle_ports;
    chk("samekey_count", 128'(bus.fifo_count_o), 128'(4'd1));
    expect_entry("samekey", 64'd5, 128'd9);
    chk("samekey_count_end", 128'(bus.fifo_count_o), 128'(4'd0));
    chk("samekey_valid_end", 128'(bus.word_valid_o), 128'(1'b0));

    // Fill past capacity with the consumer stalled
    bus.word_ready_i = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 64'(i), 128'(100 + i), 1'b0, 64'd0, 128'd0);
      tick;
      if (i == 6) chk("fill6_in_ready", 128'(bus.in_ready_o), 128'(1'b1));
      if (i == 7) chk("fill7_in_ready", 128'(bus.in_ready_o), 128'(1'b0));
      if (i == 8) chk("fill8_overflow", 128'(bus.overflow_o), 128'(1'b0));
    end
    idle_ports;
    chk("full_count",    128'(bus.fifo_count_o), 128'(4'd8));
    chk("full_overflow", 128'(bus.overflow_o),   128'(1'b1));
    chk("full_in_ready", 128'(bus.in_ready_o),   128'(1'b0));
    bus.word_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) expect_entry("drain", 64'(i), 128'(100 + i));
    chk("drain_valid_end", 128'(bus.word_valid_o), 128'(1'b0));
    chk("drain_count_end", 128'(bus.fifo_count_o), 128'(4'd0));

    // Consumer ready toggling every cycle: stalled words must hold
    bus.word_ready_i = 1'b0;
    drive(1'b1, 64'h0000_00B2_0000_00B1, 128'h000000C4_000000C3_000000C2_000000C1,
          1'b0, 64'd0, 128'd0);
    tick;
    idle_ports;
    load_entry(64'h0000_00B2_0000_00B1, 128'h000000C4_000000C3_000000C2_000000C1);
    for (int k = 0; k < en; k++) begin
      bus.word_ready_i = 1'b0;
      chk("stall_valid", 128'(bus.word_valid_o), 128'(1'b1));
      chk("stall_word",  128'(bus.word_o),       128'(ew[k]));
      chk("stall_last",  128'(bus.last_o),       128'(k == en - 1));
      tick;
      bus.word_ready_i = 1'b1;
      chk("go_word", 128'(bus.word_o), 128'(ew[k]));
      chk("go_last", 128'(bus.last_o), 128'(k == en - 1));
      tick;
    end
    hdr_seq++;
    chk("stall_count_end", 128'(bus.fifo_count_o), 128'(4'd0));
    chk("stall_valid_end", 128'(bus.word_valid_o), 128'(1'b0));

    // Reset in the middle of an entry, with a write attempted in the reset cycle
    chk("sticky_overflow", 128'(bus.overflow_o), 128'(1'b1));
    drive(1'b1, 64'h0000_00D2_0000_00D1, 128'h000000E4_000000E3_000000E2_000000E1,
          1'b0, 64'd0, 128'd0);
    tick;
    idle_ports;
    load_entry(64'h0000_00D2_0000_00D1, 128'h000000E4_000000E3_000000E2_000000E1);
    for (int k = 0; k < 3; k++) expect_word("midrst", ew[k], 1'b0);
    rst = 1'b1;
    drive(1'b1, 64'd77, 128'd77, 1'b0, 64'd0, 128'd0);
    tick;
    rst = 1'b0;
    idle_ports;
    hdr_seq = 16'd0;
    chk("midrst_valid",    128'(bus.word_valid_o), 128'(1'b0));
    chk("midrst_count",    128'(bus.fifo_count_o), 128'(4'd0));
    chk("midrst_overflow", 128'(bus.overflow_o),   128'(1'b0));
    chk("midrst_in_ready", 128'(bus.in_ready_o),   128'(1'b1));
    drive(1'b1, 64'h0000_00F2_0000_00F1, 128'h00000034_00000033_00000032_00000031,
          1'b0, 64'd0, 128'd0);
    tick;
    idle_ports;
    expect_entry("postrst", 64'h0000_00F2_0000_00F1, 128'h00000034_00000033_00000032_00000031);
    chk("postrst_count_end", 128'(bus.fifo_count_o), 128'(4'd0));

    // Two entries in one cycle from both ports: port 1 first, sequence restarts at 0
    rst = 1'b1;
    tick;
    rst = 1'b0;
    hdr_seq = 16'd0;
    drive(1'b1, 64'h0000_0012_0000_0011, 128'h00000054_00000053_00000052_00000051,
          1'b1, 64'h0000_0022_0000_0021, 128'h00000064_00000063_00000062_00000061);
    tick;
    idle_ports;
    chk("dual_count", 128'(bus.fifo_count_o), 128'(4'd2));
    expect_entry("dual_a", 64'h0000_0012_0000_0011, 128'h00000054_00000053_00000052_00000051);
    expect_entry("dual_b", 64'h0000_0022_0000_0021, 128'h00000064_00000063_00000062_00000061);
    chk("dual_count_end", 128'(bus.fifo_count_o), 128'(4'd0));
    chk("dual_valid_end", 128'(bus.word_valid_o), 128'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/commit_serializer.md
COMMIT_SERIALIZER -- requirements
Module: commit_serializer

Interface
REQ-001 The module SHALL have parameter DPI_WIDTH, default 32, as the width of one output word.
REQ-002 The module SHALL have parameter KEY_WIDTH, default 64, as the register-write address width; it SHALL be a multiple of DPI_WIDTH.
REQ-003 The module SHALL have parameter VALUE_WIDTH, default 128, as the write-data width; it SHALL be a multiple of DPI_WIDTH.
REQ-004 The module SHALL have parameter DEPTH, default 8, as the entry FIFO depth; it SHALL be a power of two and at least 2.
REQ-005 The module SHALL use one clock and a synchronous, active-high reset: clk_i  in  1  clock, all logic on rising edge; rst_i  in  1  synchronous active-high reset.
REQ-006 The module SHALL have these ports: we1_i in 1, port-1 write enable; wa1_i in KEY_WIDTH, port-1 key; wd1_i in VALUE_WIDTH, port-1 value; we2_i in 1, port-2 write enable; wa2_i in KEY_WIDTH, port-2 key; wd2_i in VALUE_WIDTH, port-2 value.
REQ-007 The module SHALL have these ports: in_ready_o out 1, high when at least 2 FIFO slots are free; word_o out DPI_WIDTH, stream word; word_valid_o out 1, word_o valid; word_ready_i in 1, consumer accepts; last_o out 1, final word of entry; fifo_count_o out $clog2(DEPTH)+1, entries held; overflow_o out 1, sticky drop flag.

Function
REQ-008 An entry SHALL be one {key, value} pair; a word transfer SHALL occur on a cycle with word_valid_o and word_ready_i both high.
REQ-009 Entry word order SHALL be: KEY_WIDTH/DPI_WIDTH key words, least-significant word first (word i = key[(i+1)*DPI_WIDTH-1 -: DPI_WIDTH]), then VALUE_WIDTH/DPI_WIDTH value words in the same order; last_o SHALL be high only on the final value word.
REQ-010 The FSM SHALL have states IDLE, KEY and VALUE: IDLE->KEY when the FIFO is non-empty; KEY->VALUE on transfer of the last key word; VALUE->KEY on transfer of the last value word if another entry remains, else VALUE->IDLE.
REQ-011 The FSM SHALL advance the word index only on a transfer; while word_valid_o is high and word_ready_i is low, word_o and last_o SHALL hold stable.
REQ-012 The FIFO entry SHALL be popped on the transfer with last_o high.
REQ-013 Latency: an entry pushed at edge N SHALL have its first word on word_o with word_valid_o high during cycle N+1 when the FIFO was empty.
REQ-014 Push order within a cycle SHALL be port 1 then port 2.
REQ-015 If we1_i and we2_i are both high and wa1_i equals wa2_i, only the port-2 pair SHALL be pushed (port 2 wins).
REQ-016 Free space for a cycle SHALL be DEPTH minus fifo_count_o, plus 1 if a pop occurs that cycle.
REQ-017 Writes exceeding free space SHALL be dropped, port 2 first, and each drop SHALL set overflow_o, which stays set until reset.
REQ-018 in_ready_o SHALL be a combinational function of the registered count and SHALL NOT depend on word_ready_i.
REQ-019 fifo_count_o SHALL update on every edge by pushes minus pops, with read/write pointers wrapping modulo DEPTH.

Reset
REQ-020 With rst_i high at a clock edge, the module SHALL clear the FIFO pointers and count, the FSM (to IDLE), the word index, overflow_o and the sequence counter, including during an in-flight entry, which is discarded.
REQ-021 After reset: word_valid_o=0, last_o=0, word_o=0, fifo_count_o=0, overflow_o=0, in_ready_o=1.
REQ-022 Pushes in the reset cycle SHALL be ignored.

Configuration
REQ-023 When macro COMMIT_SERIALIZER_HEADER_EN is defined, the FSM SHALL add state HDR ahead of KEY and each entry SHALL be prefixed by one header word {8'hA5, 8'h00, seq[15:0]}, placed in the low 32 bits, with zero fill above bit 31 when DPI_WIDTH > 32; seq SHALL start at 0 and increment (wrapping at 16'hFFFF) on each popped entry.
REQ-024 When COMMIT_SERIALIZER_HEADER_EN is undefined, no HDR state, header word or sequence counter SHALL exist.

Verification
REQ-025 The bench SHALL drive one write, wa1=64'h0000_0002_0000_0001, wd1=128'h4_3_2_1 (32-bit words), with word_ready_i=1, and SHALL check 6 words 1,2,1,2,3,4 on consecutive cycles, last_o on the 6th, and fifo_count_o returning to 0.
REQ-026 The bench SHALL drive both ports with wa1=wa2=5, wd1=7, wd2=9 and SHALL check exactly one entry with value 9.
REQ-027 The bench SHALL hold word_ready_i=0 and push 10 single writes with DEPTH=8, and SHALL check fifo_count_o=8, overflow_o=1, in_ready_o=0, and that entries 9-10 are absent after draining.
REQ-028 The bench SHALL toggle word_ready_i 1/0 each cycle and SHALL check that word_o stays stable on every stalled cycle and that the word sequence is unchanged.
REQ-029 The bench SHALL assert rst_i after the 3rd word of an entry and SHALL check word_valid_o=0 and fifo_count_o=0 on the next cycle, then a clean entry after release.
REQ-030 With COMMIT_SERIALIZER_HEADER_EN defined, the bench SHALL push 2 entries and SHALL check headers 32'hA500_0000 and 32'hA500_0001, each followed by 6 words.
